pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 35 +++
 rtl/pc_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between the PC generator (slave) and its
// surrounding pipeline (master).
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            pc_ready;
    logic [XLEN-1:0] sext_out;
    logic [XLEN-1:0] alu_out;
    logic            if_br_inst;
    logic            if_jal_inst;
    logic            flush_pc;
    logic [XLEN-1:0] new_pc;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            halt_req;
    logic            resume_req;
    logic            inst_len2;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            halted;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;

    modport master (
        output pc_ready, sext_out, alu_out, if_br_inst, if_jal_inst, flush_pc,
               new_pc, trap_valid, trap_pc, halt_req, resume_req, inst_len2,
        input  pc, pc_valid, halted, misalign_exc, misalign_addr
    );

    modport slave (
        input  pc_ready, sext_out, alu_out, if_br_inst, if_jal_inst, flush_pc,
               new_pc, trap_valid, trap_pc, halt_req, resume_req, inst_len2,
        output pc, pc_valid, halted, misalign_exc, misalign_addr
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter with BOOT/RUN/HALT fetch control and prioritised redirects.
// Define PC_RVC_EN for compressed-instruction support (2-byte steps, halfword alignment).
`ifndef RESET_PC
`define RESET_PC 32'h8000_0000
`endif

module pc_gen #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = `RESET_PC
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            halted_q;
    logic            misalign_exc_q;
    logic [XLEN-1:0] misalign_addr_q;

    logic            br_taken;
    logic            halt_now;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] flush_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] step;
    logic            flush_ok;
    logic            br_ok;
    logic            unused_inputs;

    assign br_taken  = (bus.if_br_inst & bus.alu_out[0]) | bus.if_jal_inst;
    assign halt_now  = bus.halt_req & ~bus.resume_req;
    assign flush_tgt = {bus.new_pc[XLEN-1:1], 1'b0};
    assign br_tgt    = pc_q + bus.sext_out;

`ifdef PC_RVC_EN
    assign trap_tgt      = {bus.trap_pc[XLEN-1:1], 1'b0};
    assign step          = bus.inst_len2 ? XLEN'(2) : XLEN'(4);
    assign flush_ok      = 1'b1;
    assign br_ok         = ~br_tgt[0];
    assign unused_inputs = ^{bus.alu_out[XLEN-1:1], bus.trap_pc[0], bus.new_pc[0]};
`else
    assign trap_tgt      = {bus.trap_pc[XLEN-1:2], 2'b00};
    assign step          = XLEN'(4);
    assign flush_ok      = ~flush_tgt[1];
    assign br_ok         = (br_tgt[1:0] == 2'b00);
    assign unused_inputs = ^{bus.alu_out[XLEN-1:1], bus.trap_pc[1:0], bus.new_pc[0],
                             bus.inst_len2};
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            pc_q            <= RESET_PC;
            pc_valid_q      <= 1'b0;
            halted_q        <= 1'b0;
            misalign_exc_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            // NOTE: default assignment first so the pulse clears unless a branch below re-arms it.
            misalign_exc_q <= 1'b0;
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (bus.trap_valid) begin
                        pc_q <= trap_tgt;
                    end else if (bus.flush_pc) begin
                        if (flush_ok) begin
                            pc_q <= flush_tgt;
                        end else begin
                            misalign_exc_q  <= 1'b1;
                            misalign_addr_q <= flush_tgt;
                        end
                    end else if (br_taken) begin
                        if (br_ok) begin
                            pc_q <= br_tgt;
                        end else begin
                            misalign_exc_q  <= 1'b1;
                            misalign_addr_q <= br_tgt;
                        end
                    end else if (halt_now) begin
                        // A halting fetch is not consumed; the same pc is refetched on resume.
                        state      <= HALT;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (bus.pc_ready) begin
                        pc_q <= pc_q + step;
                    end
                end
                HALT: begin
                    if (bus.trap_valid) begin
                        pc_q       <= trap_tgt;
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end else if (bus.resume_req) begin
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.halted        = halted_q;
    assign bus.misalign_exc  = misalign_exc_q;
    assign bus.misalign_addr = misalign_addr_q;

endmodule
